// File: rtl/ex_commit_stage.sv
// rtl/ex_commit_stage.sv - commit stage after execute: result register, condition codes, branch resolve, squash window
//
// Sits directly downstream of the 16-bit shifter/ALU execute stage.
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid           execute presents an instruction
//   in_result/in_rd    result and destination index
//   in_reg_we          instruction writes a register
//   in_cond/in_flag_we condition codes {S,Z,C,V} and their update enable
//   in_br/in_br_cond   branch and its condition (000 BE, 001 BLT, 010 BLE, 011 BNE, 100 B, others never)
//   in_br_target       branch target address
//   stall              downstream hold; freezes all state
//   out_valid/out_result/out_rd/out_reg_we  registered instruction to write-back
//   flags              committed {S,Z,C,V}
//   br_taken/br_target one-cycle taken-branch pulse and its target
//   squash             wrong-path discard window active
module ex_commit_stage #(
  parameter int SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_result,
  input  logic [3:0]  in_cond,
  input  logic        in_flag_we,
  input  logic [2:0]  in_rd,
  input  logic        in_reg_we,
  input  logic        in_br,
  input  logic [2:0]  in_br_cond,
  input  logic [15:0] in_br_target,
  input  logic        stall,
  output logic        out_valid,
  output logic [15:0] out_result,
  output logic [2:0]  out_rd,
  output logic        out_reg_we,
  output logic [3:0]  flags,
  output logic        br_taken,
  output logic [15:0] br_target,
  output logic        squash
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;
  localparam logic [2:0] SQ_LOAD   = 3'(SQUASH_CYCLES);

  logic [0:0] state;
  logic [2:0] sq_cnt;
  logic       br_q;
  logic       accept;
  logic       cond_true;
  logic       take;

  assign accept = in_valid & ~stall & (state == ST_IDLE);

  // Branch condition uses the committed flags register, never this
  // instruction's own in_cond, so a flag-setting branch sees the old state.
  always_comb begin
    cond_true = 1'b0;
    case (in_br_cond)
      3'b000:  cond_true = flags[2];
      3'b001:  cond_true = flags[3] ^ flags[0];
      3'b010:  cond_true = flags[2] | (flags[3] ^ flags[0]);
      3'b011:  cond_true = ~flags[2];
      3'b100:  cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign take = accept & in_br & cond_true;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= 16'h0000;
      out_rd     <= 3'd0;
      out_reg_we <= 1'b0;
      flags      <= 4'b0000;
      br_q       <= 1'b0;
      br_target  <= 16'h0000;
      state      <= ST_IDLE;
      sq_cnt     <= 3'd0;
    end else if (!stall) begin
      out_valid  <= accept;
      out_reg_we <= accept & in_reg_we;
      if (accept) begin
        out_result <= in_result;
        out_rd     <= in_rd;
      end
      if (accept && in_flag_we) begin
        flags <= in_cond;
      end
      br_q <= take;
      if (take) begin
        br_target <= in_br_target;
      end
      case (state)
        ST_IDLE: begin
          if (take) begin
            state  <= ST_SQUASH;
            sq_cnt <= SQ_LOAD;
          end
        end
        default: begin
          // The slot presented while the count is 1 is the last one dropped.
          if (sq_cnt == 3'd1) begin
            state <= ST_IDLE;
          end
          sq_cnt <= sq_cnt - 3'd1;
        end
      endcase
    end
  end

  // A pulse held by a stall stays registered and appears once stall drops.
  assign br_taken = br_q & ~stall;
  assign squash   = (state == ST_SQUASH);

endmodule
